// File: rtl/music_pkg.sv
// Shared definitions for the music player control path.
// State encoding and counter sizing helpers.
package music_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_FLAG   = 2'd2;

    localparam int SEL_W_DEF = 2;

    // Bits needed to hold values 0..m
    function automatic int cnt_w(input int m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sel_change_det_sat_cnt.sv
// Loadable saturating up-counter with a terminal-count flag.
// Used for settle and pulse counting in sel_change_det.
module sat_cnt
    import music_pkg::*;
#(
    parameter int MAX   = 1,
    parameter int TC_AT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic tc
);

    localparam int W = cnt_w(MAX);
    localparam logic [W-1:0] MAXV = W'(MAX);
    localparam logic [W-1:0] TCV  = W'(TC_AT);

    logic [W-1:0] q;

    // Clear wins over load; load starts the count at one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= W'(1);
        end else if (inc && (q != MAXV)) begin
            q <= q + W'(1);
        end
    end

    assign tc = (q == TCV);

endmodule

// File: rtl/sel_change_det.sv
// Selection-change detector: debounces the selection bus and
// raises a counter-clear flag when a new value is accepted.
module sel_change_det
    import music_pkg::*;
#(
    parameter int SEL_W      = SEL_W_DEF,
    parameter int SETTLE_CYC = 1,
    parameter int PULSE_CYC  = 1,
    parameter int ACK_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             clr_ack,
    output logic [SEL_W-1:0] sel_q,
    output logic             clr_flag,
    output logic             busy,
    output logic [7:0]       chg_cnt
);

    logic [1:0]       state;
    logic [1:0]       nxt;
    logic [SEL_W-1:0] cand;
    logic             accept;
    logic             done;
    logic             cand_ld;
    logic             s_clr, s_load, s_inc, s_tc;
    logic             p_clr, p_load, p_inc, p_tc;

    // Settle counter flags the cycle before the count reaches SETTLE_CYC
    sat_cnt #(
        .MAX   (SETTLE_CYC),
        .TC_AT (SETTLE_CYC - 1)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (s_clr),
        .load  (s_load),
        .inc   (s_inc),
        .tc    (s_tc)
    );

    sat_cnt #(
        .MAX   (PULSE_CYC),
        .TC_AT (PULSE_CYC)
    ) u_pulse (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (p_clr),
        .load  (p_load),
        .inc   (p_inc),
        .tc    (p_tc)
    );

    // Next-state and counter control
    always_comb begin
        nxt     = state;
        accept  = 1'b0;
        done    = 1'b0;
        cand_ld = 1'b0;
        s_clr   = 1'b0;
        s_load  = 1'b0;
        s_inc   = 1'b0;
        p_clr   = 1'b0;
        p_load  = 1'b0;
        p_inc   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sel_in != sel_q) begin
                    cand_ld = 1'b1;
                    if (SETTLE_CYC == 1) begin
                        accept = 1'b1;
                    end else begin
                        s_load = 1'b1;
                        nxt    = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (sel_in == cand) begin
                    if (s_tc) begin
                        accept = 1'b1;
                    end else begin
                        s_inc = 1'b1;
                    end
                end else if (sel_in == sel_q) begin
                    s_clr = 1'b1;
                    nxt   = ST_IDLE;
                end else begin
                    cand_ld = 1'b1;
                    s_load  = 1'b1;
                end
            end
            ST_FLAG: begin
                if ((ACK_MODE != 0) ? clr_ack : p_tc) begin
                    done  = 1'b1;
                    p_clr = 1'b1;
                    nxt   = ST_IDLE;
                end else begin
                    p_inc = 1'b1;
                end
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase
        if (accept) begin
            s_clr  = 1'b1;
            p_load = 1'b1;
            nxt    = ST_FLAG;
        end
    end

    // State, candidate and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cand     <= '0;
            sel_q    <= '0;
            clr_flag <= 1'b0;
            chg_cnt  <= 8'd0;
        end else begin
            state <= nxt;
            if (cand_ld) begin
                cand <= sel_in;
            end
            if (accept) begin
                sel_q    <= sel_in;
                clr_flag <= 1'b1;
                chg_cnt  <= chg_cnt + 8'd1;
            end else if (done) begin
                clr_flag <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sel_change_det.sv
// Bench for sel_change_det: three configurations against a
// run-length based model, plus literal spot checks.
module tb_sel_change_det;

    localparam int N = 3;
    localparam int SC [N] = '{1, 4, 3};
    localparam int PC [N] = '{1, 3, 2};
    localparam int AM [N] = '{0, 0, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sel_in = 2'd0;
    logic       clr_ack = 1'b0;

    logic [1:0] q_o [N];
    logic       f_o [N];
    logic       b_o [N];
    logic [7:0] c_o [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sel_change_det #(
        .SEL_W(2), .SETTLE_CYC(1), .PULSE_CYC(1), .ACK_MODE(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .clr_ack(clr_ack),
        .sel_q(q_o[0]), .clr_flag(f_o[0]), .busy(b_o[0]),
        .chg_cnt(c_o[0])
    );

    sel_change_det #(
        .SEL_W(2), .SETTLE_CYC(4), .PULSE_CYC(3), .ACK_MODE(0)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .clr_ack(clr_ack),
        .sel_q(q_o[1]), .clr_flag(f_o[1]), .busy(b_o[1]),
        .chg_cnt(c_o[1])
    );

    sel_change_det #(
        .SEL_W(2), .SETTLE_CYC(3), .PULSE_CYC(2), .ACK_MODE(1)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .clr_ack(clr_ack),
        .sel_q(q_o[2]), .clr_flag(f_o[2]), .busy(b_o[2]),
        .chg_cnt(c_o[2])
    );

    // Model: a value is accepted once it differs from the accepted
    // value and has been sampled SETTLE_CYC times in a row since the
    // last flag ended; the flag then lasts PULSE_CYC cycles or until ack.
    logic [1:0] m_q   [N] = '{default: 2'd0};
    logic [1:0] lastv [N] = '{default: 2'd0};
    logic       m_f   [N] = '{default: 1'b0};
    logic       m_b   [N] = '{default: 1'b0};
    logic [7:0] m_c   [N] = '{default: 8'd0};
    int         run   [N] = '{default: 0};
    int         fl_n  [N] = '{default: 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_q[i]   <= 2'd0;
                lastv[i] <= 2'd0;
                m_f[i]   <= 1'b0;
                m_b[i]   <= 1'b0;
                m_c[i]   <= 8'd0;
                run[i]   <= 0;
                fl_n[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                logic [1:0] q;
                logic [1:0] lv;
                logic       f;
                logic       b;
                logic [7:0] c;
                int         r;
                int         n;
                q  = m_q[i];
                lv = lastv[i];
                f  = m_f[i];
                c  = m_c[i];
                r  = run[i];
                n  = fl_n[i];
                if (f) begin
                    if ((AM[i] != 0) ? clr_ack : (n >= PC[i])) begin
                        f = 1'b0;
                        r = 0;
                        b = 1'b0;
                    end else begin
                        n = n + 1;
                        b = 1'b1;
                    end
                end else begin
                    if (r > 0 && sel_in == lv) r = r + 1;
                    else r = 1;
                    lv = sel_in;
                    if (sel_in != q && r >= SC[i]) begin
                        q = sel_in;
                        f = 1'b1;
                        n = 1;
                        c = c + 8'd1;
                    end
                    b = f || (sel_in != q);
                end
                m_q[i]   <= q;
                lastv[i] <= lv;
                m_f[i]   <= f;
                m_b[i]   <= b;
                m_c[i]   <= c;
                run[i]   <= r;
                fl_n[i]  <= n;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d.sel_q", i), 32'(q_o[i]), 32'(m_q[i]));
            chk($sformatf("u%0d.clr_flag", i), 32'(f_o[i]), 32'(m_f[i]));
            chk($sformatf("u%0d.busy", i), 32'(b_o[i]), 32'(m_b[i]));
            chk($sformatf("u%0d.chg_cnt", i), 32'(c_o[i]), 32'(m_c[i]));
        end
    end

    task automatic all_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s u%0d.sel_q", tag, i), 32'(q_o[i]), 0);
            chk($sformatf("%s u%0d.flag", tag, i), 32'(f_o[i]), 0);
            chk($sformatf("%s u%0d.busy", tag, i), 32'(b_o[i]), 0);
            chk($sformatf("%s u%0d.cnt", tag, i), 32'(c_o[i]), 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0 -> 2 seen by all three configurations
        sel_in = 2'd2;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            case (k)
                1: begin
                    chk("d1 u0.flag", 32'(f_o[0]), 1);
                    chk("d1 u0.sel_q", 32'(q_o[0]), 2);
                    chk("d1 u0.cnt", 32'(c_o[0]), 1);
                    chk("d1 u1.busy", 32'(b_o[1]), 1);
                end
                2: chk("d2 u0.flag", 32'(f_o[0]), 0);
                3: begin
                    chk("d3 u2.flag", 32'(f_o[2]), 1);
                    chk("d3 u1.flag", 32'(f_o[1]), 0);
                end
                4: begin
                    chk("d4 u1.flag", 32'(f_o[1]), 1);
                    chk("d4 u1.sel_q", 32'(q_o[1]), 2);
                end
                6: chk("d6 u1.flag", 32'(f_o[1]), 1);
                7: chk("d7 u1.flag", 32'(f_o[1]), 0);
                13: chk("d13 u2.flag held", 32'(f_o[2]), 1);
                default: ;
            endcase
        end
        clr_ack = 1'b1;
        @(negedge clk);
        clr_ack = 1'b0;
        chk("ack u2.flag", 32'(f_o[2]), 0);
        chk("ack u2.cnt", 32'(c_o[2]), 1);

        // 2 -> 3 for two samples then back to 2
        sel_in = 2'd3;
        repeat (2) @(negedge clk);
        sel_in = 2'd2;
        repeat (3) @(negedge clk);
        chk("rev u1.sel_q", 32'(q_o[1]), 2);
        chk("rev u1.cnt", 32'(c_o[1]), 1);
        chk("rev u1.busy", 32'(b_o[1]), 0);
        chk("rev u0.cnt", 32'(c_o[0]), 3);

        // 2 -> 1 for two samples -> 3 held: candidate restarts
        sel_in = 2'd1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) sel_in = 2'd3;
            if (k == 5) chk("rst u1.flag early", 32'(f_o[1]), 0);
        end
        chk("rst u1.flag", 32'(f_o[1]), 1);
        chk("rst u1.sel_q", 32'(q_o[1]), 3);

        // Asynchronous reset mid-FLAG
        #2 rst_n = 1'b0;
        #1 all_zero("async_flag");
        @(negedge clk);
        sel_in = 2'd0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-SETTLE
        sel_in = 2'd1;
        repeat (2) @(negedge clk);
        chk("mid u1.busy", 32'(b_o[1]), 1);
        #2 rst_n = 1'b0;
        #1 all_zero("async_settle");
        @(negedge clk);
        sel_in = 2'd0;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post u1.flag", 32'(f_o[1]), 0);
        chk("post u1.cnt", 32'(c_o[1]), 0);

        // 256 accepted changes wrap the counter
        for (int t = 0; t < 256; t++) begin
            sel_in = sel_in ^ 2'd1;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("wrap u0.cnt", 32'(c_o[0]), 0);
        chk("wrap u0.sel_q", 32'(q_o[0]), 0);

        // Random selection traffic with acks and resets
        for (int s = 0; s < 600; s++) begin
            int hold;
            hold = $urandom_range(1, 8);
            sel_in = 2'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
                clr_ack = ($urandom_range(0, 4) == 0);
                @(negedge clk);
            end
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        clr_ack = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
